// File: rtl/rx_lane_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rx_lane_arbiter_pkg
// Shared definitions for the receive lane arbiter:
//   - default byte width, per-lane FIFO depth and pointer width
//   - lane count and lane index width
//   - output-stage FSM state encoding
//   - round-robin grant helper used by the arbiter
// -----------------------------------------------------------------------------
package rx_lane_arbiter_pkg;

   localparam int DATA_W    = 8;
   localparam int DEPTH     = 4;
   localparam int ADDR_W    = 2;
   localparam int NUM_LANES = 4;
   localparam int LANE_W    = 2;

   typedef enum logic {
      ST_EMPTY  = 1'b0,
      ST_LOADED = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic              found;
      logic [LANE_W-1:0] lane;
   } grant_t;

   // Pick the first requesting lane after 'last' (last+1 .. last+4, mod 4).
   // The loop walks from the farthest candidate to the nearest so the nearest
   // requester overwrites the others and wins.
   function automatic grant_t rr_pick(input logic [NUM_LANES-1:0] req,
                                      input logic [LANE_W-1:0]    last);
      grant_t            g;
      logic [LANE_W-1:0] idx;
      g.found = 1'b0;
      g.lane  = last;
      for (int k = NUM_LANES; k >= 1; k--) begin
         idx     = last + LANE_W'(k);
         g.found = g.found | req[idx];
         g.lane  = req[idx] ? idx : g.lane;
      end
      return g;
   endfunction

endpackage

// File: rtl/rx_lane_arbiter_fifo.sv
// -----------------------------------------------------------------------------
// lane_fifo
// Single-lane synchronous FIFO with a sticky overflow flag.
// Ports:
//   clk      - block clock
//   reset    - synchronous active-low reset (pointers and overflow cleared)
//   push     - write request; dropped (and overflow set) when full without pop
//   din      - write data
//   pop      - read request; ignored while empty
//   dout     - head-of-FIFO data (combinational from read pointer)
//   full     - DEPTH entries held
//   empty    - zero entries held
//   overflow - sticky: a pushed byte was dropped since reset
// -----------------------------------------------------------------------------
module lane_fifo #(
   parameter int DATA_W = rx_lane_arbiter_pkg::DATA_W,
   parameter int DEPTH  = rx_lane_arbiter_pkg::DEPTH,
   parameter int ADDR_W = rx_lane_arbiter_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic              overflow
);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [ADDR_W:0]   wr_ptr_r;
   logic [ADDR_W:0]   rd_ptr_r;
   logic [ADDR_W:0]   count_s;
   logic              rd_en_s;
   logic              wr_en_s;
   logic              overflow_r;

   // Extra pointer MSB separates the full and empty cases on wrap-around.
   assign count_s  = wr_ptr_r - rd_ptr_r;
   assign full     = (count_s == (ADDR_W+1)'(DEPTH));
   assign empty    = (count_s == {(ADDR_W+1){1'b0}});
   // A pop frees a slot in the same cycle, so a full lane still accepts a push.
   assign rd_en_s  = pop & ~empty;
   assign wr_en_s  = push & (~full | rd_en_s);
   assign dout     = mem_r[rd_ptr_r[ADDR_W-1:0]];
   assign overflow = overflow_r;

   // Pointer and sticky overflow update
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_r   <= {(ADDR_W+1){1'b0}};
         rd_ptr_r   <= {(ADDR_W+1){1'b0}};
         overflow_r <= 1'b0;
      end else begin
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + (ADDR_W+1)'(1);
         end
         if (rd_en_s) begin
            rd_ptr_r <= rd_ptr_r + (ADDR_W+1)'(1);
         end
         if (push & ~wr_en_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // Storage write; contents need no reset because the pointers define validity
   always_ff @(posedge clk) begin
      if (reset && wr_en_s) begin
         mem_r[wr_ptr_r[ADDR_W-1:0]] <= din;
      end
   end

endmodule

// File: rtl/rx_lane_arbiter.sv
// -----------------------------------------------------------------------------
// rx_lane_arbiter
// Buffers the four recovered PHY byte lanes in per-lane FIFOs and merges them
// round-robin into one registered byte stream with a valid/ready handshake.
// Ports:
//   clk, reset                 - block clock, synchronous active-low reset
//   data_in0..3, valid_in0..3  - recovered lane bytes and their qualifiers
//   ready_in                   - downstream accepts data_out this cycle
//   data_out, lane_id          - merged registered byte and its source lane
//   valid_out                  - data_out/lane_id hold a valid byte
//   full, empty                - per-lane FIFO status (bit N = lane N)
//   overflow                   - per-lane sticky dropped-byte flag
// -----------------------------------------------------------------------------
module rx_lane_arbiter #(
   parameter int DATA_W = rx_lane_arbiter_pkg::DATA_W,
   parameter int DEPTH  = rx_lane_arbiter_pkg::DEPTH,
   parameter int ADDR_W = rx_lane_arbiter_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in0,
   input  logic [DATA_W-1:0] data_in1,
   input  logic [DATA_W-1:0] data_in2,
   input  logic [DATA_W-1:0] data_in3,
   input  logic              valid_in0,
   input  logic              valid_in1,
   input  logic              valid_in2,
   input  logic              valid_in3,
   input  logic              ready_in,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic [1:0]        lane_id,
   output logic [3:0]        full,
   output logic [3:0]        empty,
   output logic [3:0]        overflow
);

   import rx_lane_arbiter_pkg::*;

   logic [DATA_W-1:0]    din_s  [NUM_LANES];
   logic [DATA_W-1:0]    dout_s [NUM_LANES];
   logic [NUM_LANES-1:0] push_s;
   logic [NUM_LANES-1:0] pop_s;

   arb_state_t           state_r;
   arb_state_t           state_nx_s;
   logic [DATA_W-1:0]    data_r;
   logic [DATA_W-1:0]    data_nx_s;
   logic [LANE_W-1:0]    lane_r;
   logic [LANE_W-1:0]    lane_nx_s;
   logic [LANE_W-1:0]    last_grant_r;
   logic [LANE_W-1:0]    last_grant_nx_s;
   grant_t               grant_s;
   logic                 load_s;

   assign din_s[0] = data_in0;
   assign din_s[1] = data_in1;
   assign din_s[2] = data_in2;
   assign din_s[3] = data_in3;
   assign push_s   = {valid_in3, valid_in2, valid_in1, valid_in0};

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      lane_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH),
         .ADDR_W (ADDR_W)
      ) u_fifo (
         .clk      (clk),
         .reset    (reset),
         .push     (push_s[g]),
         .din      (din_s[g]),
         .pop      (pop_s[g]),
         .dout     (dout_s[g]),
         .full     (full[g]),
         .empty    (empty[g]),
         .overflow (overflow[g])
      );
   end

   // Grant is based on FIFO state before this cycle's writes land.
   assign grant_s = rr_pick(~empty, last_grant_r);

   // Output FSM: next state, load decision and pop request
   always_comb begin
      state_nx_s      = state_r;
      data_nx_s       = data_r;
      lane_nx_s       = lane_r;
      last_grant_nx_s = last_grant_r;
      load_s          = 1'b0;
      pop_s           = {NUM_LANES{1'b0}};
      case (state_r)
         ST_EMPTY: begin
            if (grant_s.found) begin
               load_s = 1'b1;
            end else begin
               state_nx_s = ST_EMPTY;
            end
         end
         ST_LOADED: begin
            if (ready_in) begin
               if (grant_s.found) begin
                  load_s = 1'b1;
               end else begin
                  state_nx_s = ST_EMPTY;
               end
            end else begin
               state_nx_s = ST_LOADED;
            end
         end
         default: begin
            state_nx_s = ST_EMPTY;
         end
      endcase
      if (load_s) begin
         state_nx_s      = ST_LOADED;
         data_nx_s       = dout_s[grant_s.lane];
         lane_nx_s       = grant_s.lane;
         last_grant_nx_s = grant_s.lane;
         pop_s           = {{(NUM_LANES-1){1'b0}}, 1'b1} << grant_s.lane;
      end else begin
         pop_s = {NUM_LANES{1'b0}};
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= ST_EMPTY;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Registered output byte, lane tag and round-robin pointer
   always_ff @(posedge clk) begin
      if (!reset) begin
         data_r       <= {DATA_W{1'b0}};
         lane_r       <= {LANE_W{1'b0}};
         last_grant_r <= 2'd3;
      end else begin
         data_r       <= data_nx_s;
         lane_r       <= lane_nx_s;
         last_grant_r <= last_grant_nx_s;
      end
   end

   assign data_out  = data_r;
   assign lane_id   = lane_r;
   assign valid_out = (state_r == ST_LOADED);

endmodule

// File: tb/tb_rx_lane_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rx_lane_arbiter
// Queue-based reference model of the four-lane arbiter, compared against the
// DUT on every falling edge, plus directed sequences with literal expectations
// and a randomized phase with occasional resets.
// -----------------------------------------------------------------------------
module tb_rx_lane_arbiter;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] din [4];
   logic [3:0] vin;
   logic       ready_in;

   logic [7:0] data_out;
   logic       valid_out;
   logic [1:0] lane_id;
   logic [3:0] full;
   logic [3:0] empty;
   logic [3:0] overflow;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rx_lane_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .data_in0  (din[0]),
      .data_in1  (din[1]),
      .data_in2  (din[2]),
      .data_in3  (din[3]),
      .valid_in0 (vin[0]),
      .valid_in1 (vin[1]),
      .valid_in2 (vin[2]),
      .valid_in3 (vin[3]),
      .ready_in  (ready_in),
      .data_out  (data_out),
      .valid_out (valid_out),
      .lane_id   (lane_id),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] lq [4][$];
   logic [7:0] m_data  = 8'h00;
   logic       m_valid = 1'b0;
   logic [1:0] m_lane  = 2'd0;
   int         m_last  = 3;
   logic [3:0] m_ovf   = 4'h0;

   // Model state advances on each rising edge from the inputs held there.
   always @(posedge clk) begin
      int  pl;
      bit  found;
      if (!reset) begin
         for (int i = 0; i < 4; i++) lq[i].delete();
         m_data  = 8'h00;
         m_valid = 1'b0;
         m_lane  = 2'd0;
         m_last  = 3;
         m_ovf   = 4'h0;
      end else begin
         // Output side first: a free or accepted output register takes the
         // next lane in round-robin order among lanes that were non-empty.
         if (!m_valid || ready_in) begin
            found = 1'b0;
            pl    = 0;
            for (int k = 1; k <= 4; k++) begin
               if (!found && lq[(m_last + k) % 4].size() > 0) begin
                  found = 1'b1;
                  pl    = (m_last + k) % 4;
               end
            end
            if (found) begin
               m_data  = lq[pl].pop_front();
               m_lane  = 2'(pl);
               m_last  = pl;
               m_valid = 1'b1;
            end else begin
               m_valid = 1'b0;
            end
         end
         // Writes after the pop, so a popped full lane accepts a new byte.
         for (int i = 0; i < 4; i++) begin
            if (vin[i]) begin
               if (lq[i].size() < DEPTH) lq[i].push_back(din[i]);
               else m_ovf[i] = 1'b1;
            end
         end
      end
   end

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge clk) begin
      logic [3:0] mf;
      logic [3:0] me;
      for (int i = 0; i < 4; i++) begin
         mf[i] = (lq[i].size() == DEPTH);
         me[i] = (lq[i].size() == 0);
      end
      chk("model_valid_out", 32'(valid_out), 32'(m_valid));
      chk("model_data_out",  32'(data_out),  32'(m_data));
      chk("model_lane_id",   32'(lane_id),   32'(m_lane));
      chk("model_full",      32'(full),      32'(mf));
      chk("model_empty",     32'(empty),     32'(me));
      chk("model_overflow",  32'(overflow),  32'(m_ovf));
   end

   task automatic pulse_reset();
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      reset    = 1'b0;
      vin      = 4'h0;
      ready_in = 1'b1;
      for (int i = 0; i < 4; i++) din[i] = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_valid",    32'(valid_out), 32'd0);
      chk("rst_empty",    32'(empty),     32'hF);
      chk("rst_full",     32'(full),      32'h0);
      chk("rst_overflow", 32'(overflow),  32'h0);
      chk("rst_data",     32'(data_out),  32'h0);
      chk("rst_lane",     32'(lane_id),   32'h0);
      reset = 1'b1;

      // single byte on lane 2
      vin[2] = 1'b1; din[2] = 8'hA5;
      @(negedge clk);
      vin = 4'h0;
      @(negedge clk);
      chk("single_valid", 32'(valid_out), 32'd1);
      chk("single_data",  32'(data_out),  32'hA5);
      chk("single_lane",  32'(lane_id),   32'd2);
      @(negedge clk);
      chk("single_drop_valid", 32'(valid_out), 32'd0);

      // round-robin from a fresh pointer
      pulse_reset();
      for (int i = 0; i < 4; i++) begin
         vin[i] = 1'b1;
         din[i] = 8'((i + 1) * 16);
      end
      @(negedge clk);
      vin = 4'h0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rr_valid", 32'(valid_out), 32'd1);
         chk("rr_data",  32'(data_out),  32'((i + 1) * 16));
         chk("rr_lane",  32'(lane_id),   32'(i));
      end
      @(negedge clk);
      chk("rr_end_valid", 32'(valid_out), 32'd0);

      // backpressure on lane 1
      ready_in = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         vin[1] = 1'b1; din[1] = 8'(i);
         @(negedge clk);
         if (i == 4) chk("bp_not_full_yet", 32'(full[1]), 32'd0);
      end
      vin = 4'h0;
      chk("bp_full",      32'(full[1]),  32'd1);
      chk("bp_hold_data", 32'(data_out), 32'h01);
      ready_in = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         @(negedge clk);
         chk("bp_drain_data", 32'(data_out), 32'(i));
      end
      @(negedge clk);
      chk("bp_end_valid", 32'(valid_out), 32'd0);

      // overflow on lane 3
      ready_in = 1'b0;
      for (int i = 0; i < 6; i++) begin
         vin[3] = 1'b1; din[3] = 8'(8'hC0 + i);
         @(negedge clk);
      end
      vin = 4'h0;
      chk("ovf_set", 32'(overflow[3]), 32'd1);
      ready_in = 1'b1;
      repeat (8) @(negedge clk);
      chk("ovf_sticky", 32'(overflow), 32'h8);
      chk("ovf_drained_valid", 32'(valid_out), 32'd0);
      chk("ovf_drained_empty", 32'(empty), 32'hF);

      // wrap-around on lane 0 with ready toggling
      pulse_reset();
      for (int i = 0; i < 20; i++) begin
         vin[0] = 1'b1; din[0] = 8'(i); ready_in = 1'b1;
         @(negedge clk);
         vin = 4'h0; ready_in = 1'b0;
         @(negedge clk);
         chk("wrap_data", 32'(data_out), 32'(i));
      end
      ready_in = 1'b1;
      repeat (4) @(negedge clk);
      chk("wrap_overflow", 32'(overflow), 32'h0);
      chk("wrap_empty",    32'(empty),    32'hF);

      // reset in the middle of traffic
      ready_in = 1'b0;
      for (int c = 0; c < 2; c++) begin
         vin = 4'b0111;
         for (int i = 0; i < 3; i++) din[i] = 8'(8'hA0 + 16 * i + c);
         @(negedge clk);
      end
      vin = 4'h0;
      chk("mid_valid_before", 32'(valid_out), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("mid_valid_after", 32'(valid_out), 32'd0);
      chk("mid_empty_after", 32'(empty),     32'hF);
      vin[0] = 1'b1; din[0] = 8'h77;
      @(negedge clk);
      vin = 4'h0; ready_in = 1'b1;
      @(negedge clk);
      chk("mid_next_valid", 32'(valid_out), 32'd1);
      chk("mid_next_lane",  32'(lane_id),   32'd0);
      chk("mid_next_data",  32'(data_out),  32'h77);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         vin      = 4'($urandom & $urandom);
         for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
         ready_in = ($urandom_range(0, 3) != 0);
         reset    = ($urandom_range(0, 299) != 0);
         @(negedge clk);
      end
      reset = 1'b1; vin = 4'h0; ready_in = 1'b1;
      repeat (10) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
